// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: machine word, the NOP used as a pipeline
// bubble, and the pipeline-latch control states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam lc3b_word lc3b_nop = 16'h0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // Number of bundles held by the latch in a given state.
    function automatic logic [1:0] occupancy_of(input pipe_state_t s);
        case (s)
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Load-enabled register, asynchronously cleared by an active-high reset.
module pipe_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch: valid/ready handshake with a two-entry skid
// buffer (registered in_ready), synchronous flush and bubble-IR injection.
module pipe_stage_latch
    import lc3b_types::*;
#(
    parameter int                WIDTH        = 16,
    parameter int                NUM_FIELDS   = 5,
    parameter int                BUBBLE_FIELD = 0,
    parameter logic [WIDTH-1:0]  BUBBLE_VALUE = WIDTH'(lc3b_nop)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_FIELDS*WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_FIELDS*WIDTH-1:0] out_data,
    output logic [1:0]                  occupancy
);

    localparam int DW = NUM_FIELDS * WIDTH;

    pipe_state_t   state;
    pipe_state_t   state_next;
    logic          main_load;
    logic          skid_load;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          accept;
    logic          drain;

    // Handshake outputs depend only on the state register, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign occupancy = occupancy_of(state);

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_data;

        case (state)
            EMPTY: begin
                if (accept) begin
                    main_load  = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load  = 1'b1;
                    state_next = SKID;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (drain) begin
                    main_load  = 1'b1;
                    main_d     = skid_q;
                    state_next = FULL;
                end
            end
            default: state_next = EMPTY;
        endcase

        // Flush discards held and incoming bundles without touching the data.
        if (flush) begin
            state_next = EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_next;
    end

    pipe_reg #(.WIDTH(DW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_reg #(.WIDTH(DW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

    // While invalid, the IR slot carries a NOP; other fields show stale MAIN.
    always_comb begin
        out_data = main_q;
        if (!out_valid)
            out_data[BUBBLE_FIELD*WIDTH +: WIDTH] = BUBBLE_VALUE;
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench driving the default instance and a narrow 3x8 instance
// (bubble field 2, bubble value FF) with the same handshake sequence.
module tb_pipe_stage_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] tag_in;

    logic [79:0] in_data_a;
    logic [79:0] out_data_a;
    logic        in_ready_a, out_valid_a;
    logic [1:0]  occupancy_a;

    logic [23:0] in_data_b;
    logic [23:0] out_data_b;
    logic        in_ready_b, out_valid_b;
    logic [1:0]  occupancy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Field k of the wide bundle is tag*(k+1); of the narrow one tag[7:0]*(k+1).
    function automatic logic [79:0] make_a(input logic [15:0] tag);
        logic [79:0] d;
        for (int k = 0; k < 5; k++)
            d[k*16 +: 16] = 16'(tag * 16'(k + 1));
        return d;
    endfunction

    function automatic logic [23:0] make_b(input logic [15:0] tag);
        logic [23:0] d;
        for (int k = 0; k < 3; k++)
            d[k*8 +: 8] = 8'(tag[7:0] * 8'(k + 1));
        return d;
    endfunction

    assign in_data_a = make_a(tag_in);
    assign in_data_b = make_b(tag_in);

    pipe_stage_latch u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .occupancy (occupancy_a)
    );

    pipe_stage_latch #(
        .WIDTH        (8),
        .NUM_FIELDS   (3),
        .BUBBLE_FIELD (2),
        .BUBBLE_VALUE (8'hFF)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .occupancy (occupancy_b)
    );

    task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks both instances; main_tag is the bundle expected in MAIN.
    task automatic expect_all(input string name, input logic v, input logic r,
                              input logic [1:0] occ, input logic [15:0] main_tag);
        logic [79:0] ea;
        logic [23:0] eb;
        ea = make_a(main_tag);
        eb = make_b(main_tag);
        if (!v) begin
            ea[15:0]  = 16'h0000;
            eb[23:16] = 8'hFF;
        end
        check_val({name, " a.out_valid"}, 80'(out_valid_a), 80'(v));
        check_val({name, " a.in_ready"},  80'(in_ready_a),  80'(r));
        check_val({name, " a.occupancy"}, 80'(occupancy_a), 80'(occ));
        check_val({name, " a.out_data"},  out_data_a,       ea);
        check_val({name, " b.out_valid"}, 80'(out_valid_b), 80'(v));
        check_val({name, " b.in_ready"},  80'(in_ready_b),  80'(r));
        check_val({name, " b.occupancy"}, 80'(occupancy_b), 80'(occ));
        check_val({name, " b.out_data"},  80'(out_data_b),  80'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tag_in    = 16'h1111;

        // Reset with live input driven: nothing may be captured.
        #3;
        expect_all("reset", 1'b0, 1'b1, 2'd0, 16'h0000);
        check_val("reset b.raw", 80'(out_data_b), 80'(24'hFF0000));
        step();
        expect_all("reset_held", 1'b0, 1'b1, 2'd0, 16'h0000);
        rst = 1'b0;

        // Streaming at full rate: each bundle visible one cycle after accept.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tag_in = 16'h1000 + 16'(i);
            step();
            expect_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 16'h1000 + 16'(i));
        end
        in_valid = 1'b0;
        step();
        expect_all("stream_end", 1'b0, 1'b1, 2'd0, 16'h1007);

        // Back-to-back A, B, C under stall; C must be refused and resent.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag_in    = 16'hA0A1;
        step();
        expect_all("stall_a", 1'b1, 1'b1, 2'd1, 16'hA0A1);
        tag_in = 16'hB0B2;
        step();
        expect_all("stall_b", 1'b1, 1'b0, 2'd2, 16'hA0A1);
        tag_in = 16'hC0C3;
        step();
        expect_all("stall_c_refused", 1'b1, 1'b0, 2'd2, 16'hA0A1);
        out_ready = 1'b1;
        step();
        expect_all("release_b", 1'b1, 1'b1, 2'd1, 16'hB0B2);
        step();
        expect_all("release_c", 1'b1, 1'b1, 2'd1, 16'hC0C3);
        in_valid = 1'b0;
        step();
        expect_all("release_empty", 1'b0, 1'b1, 2'd0, 16'hC0C3);

        // Flush from SKID together with a new bundle on the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag_in    = 16'h2222;
        step();
        tag_in = 16'h3333;
        step();
        expect_all("pre_flush", 1'b1, 1'b0, 2'd2, 16'h2222);
        tag_in = 16'h4444;
        flush  = 1'b1;
        step();
        expect_all("flush", 1'b0, 1'b1, 2'd0, 16'h2222);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        expect_all("post_flush", 1'b0, 1'b1, 2'd0, 16'h2222);

        // Simultaneous accept and drain in FULL.
        in_valid = 1'b1;
        tag_in   = 16'h5555;
        step();
        expect_all("full_5555", 1'b1, 1'b1, 2'd1, 16'h5555);
        tag_in    = 16'hABCD;
        out_ready = 1'b1;
        step();
        expect_all("acc_drain", 1'b1, 1'b1, 2'd1, 16'hABCD);
        in_valid = 1'b0;
        step();
        expect_all("acc_drain_end", 1'b0, 1'b1, 2'd0, 16'hABCD);

        // Asynchronous reset while two bundles are held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tag_in    = 16'h6666;
        step();
        tag_in = 16'h7777;
        step();
        expect_all("pre_reset_skid", 1'b1, 1'b0, 2'd2, 16'h6666);
        #2;
        rst = 1'b1;
        #1;
        expect_all("async_reset", 1'b0, 1'b1, 2'd0, 16'h0000);
        #1;
        rst    = 1'b0;
        tag_in = 16'h1234;
        step();
        expect_all("first_after_reset", 1'b1, 1'b1, 2'd1, 16'h1234);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        expect_all("final_drain", 1'b0, 1'b1, 2'd0, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
